// File: rtl/axil_rr_arbiter_pkg.sv
// Shared register map, field indices and response codes for the AXI4-Lite
// controlled round-robin arbiter.
package axil_rr_arbiter_pkg;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_MASK   = 8'h04;
  localparam logic [7:0] OFF_STATUS = 8'h08;
  localparam logic [7:0] OFF_GCNT   = 8'h0C;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    REG_CTRL   = OFF_CTRL[3:2],
    REG_MASK   = OFF_MASK[3:2],
    REG_STATUS = OFF_STATUS[3:2],
    REG_GCNT   = OFF_GCNT[3:2]
  } reg_sel_e;

  // Byte-lane merge of a write into the current register image.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) merged[8*b +: 8] = new_val[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axil_rr_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: first set request at or after
// i_start, wrapping from NUM_REQ-1 back to 0.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_start,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  always_comb begin : search
    int pos;
    logic [IDX_W-1:0] idx;
    // NOTE: every output and local gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    pos     = 0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(i_start) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      idx = IDX_W'(pos);
      if (!o_valid && i_req[idx]) begin
        o_valid    = 1'b1;
        o_gnt[idx] = 1'b1;
        o_idx      = idx;
      end
    end
  end

endmodule

// File: rtl/axil_rr_arbiter.sv
// Round-robin / fixed-priority arbiter with an AXI4-Lite register slave
// for enable, mode, request mask, grant status and grant counting.
module axil_rr_arbiter
  import axil_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 5,
  parameter int CNT_W   = 16
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
  input  logic                S_AXI_AWVALID,
  output logic                S_AXI_AWREADY,
  input  logic [31:0]         S_AXI_WDATA,
  input  logic [3:0]          S_AXI_WSTRB,
  input  logic                S_AXI_WVALID,
  output logic                S_AXI_WREADY,
  output logic [1:0]          S_AXI_BRESP,
  output logic                S_AXI_BVALID,
  input  logic                S_AXI_BREADY,
  input  logic [ADDR_W-1:0]   S_AXI_ARADDR,
  input  logic                S_AXI_ARVALID,
  output logic                S_AXI_ARREADY,
  output logic [31:0]         S_AXI_RDATA,
  output logic [1:0]          S_AXI_RRESP,
  output logic                S_AXI_RVALID,
  input  logic                S_AXI_RREADY,
  input  logic [NUM_REQ-1:0]  req,
  output logic [NUM_REQ-1:0]  gnt
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic               r_awready, r_bvalid, r_arready, r_rvalid;
  logic [1:0]         r_bresp, r_rresp;
  logic [31:0]        r_rdata;
  logic [1:0]         r_ctrl;
  logic [NUM_REQ-1:0] r_mask;
  logic [CNT_W-1:0]   r_gcnt;
  logic [1:0]         r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [IDX_W-1:0]   r_last;

  logic               w_wr_fire, w_rd_fire, w_wr_mapped, w_rd_mapped;
  reg_sel_e           w_wr_sel, w_rd_sel;
  logic [31:0]        w_ctrl_wr, w_mask_wr, w_rdata;
  logic [NUM_REQ-1:0] w_eligible, w_pick_gnt, w_gnt_nxt;
  logic [IDX_W-1:0]   w_start, w_pick_idx;
  logic               w_pick_valid, w_grant_start;
  logic [1:0]         w_state_nxt;
  logic               w_unused;

  assign w_wr_fire   = r_awready && S_AXI_AWVALID && S_AXI_WVALID;
  assign w_rd_fire   = r_arready && S_AXI_ARVALID;
  assign w_wr_mapped = (S_AXI_AWADDR >> 4) == '0;
  assign w_rd_mapped = (S_AXI_ARADDR >> 4) == '0;
  assign w_wr_sel    = reg_sel_e'(S_AXI_AWADDR[3:2]);
  assign w_rd_sel    = reg_sel_e'(S_AXI_ARADDR[3:2]);
  assign w_ctrl_wr   = apply_wstrb(32'(r_ctrl), S_AXI_WDATA, S_AXI_WSTRB);
  assign w_mask_wr   = apply_wstrb(32'(r_mask), S_AXI_WDATA, S_AXI_WSTRB);
  assign w_unused    = ^{w_ctrl_wr, w_mask_wr};

  // Write channel: one-cycle ready pulse, response held until BREADY.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      r_awready <= !r_awready && !r_bvalid && S_AXI_AWVALID && S_AXI_WVALID;
      if (w_wr_fire) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_mapped ? RESP_OKAY : RESP_SLVERR;
      end else if (S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_rd_mapped) begin
      case (w_rd_sel)
        REG_CTRL:   w_rdata = 32'(r_ctrl);
        REG_MASK:   w_rdata = 32'(r_mask);
        REG_STATUS: begin
          w_rdata     = 32'(r_gnt);
          w_rdata[31] = |r_gnt;
        end
        default:    w_rdata = 32'(r_gcnt);
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      r_arready <= !r_arready && !r_rvalid && S_AXI_ARVALID;
      if (w_rd_fire) begin
        r_rvalid <= 1'b1;
        r_rresp  <= w_rd_mapped ? RESP_OKAY : RESP_SLVERR;
        r_rdata  <= w_rdata;
      end else if (S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // Fixed mode always searches from index 0; round-robin from last_owner+1.
  assign w_eligible = r_ctrl[CTRL_EN] ? (req & r_mask) : '0;
  assign w_start    = r_ctrl[CTRL_MODE] ? '0 :
                      ((r_last == LAST_IDX) ? '0 : r_last + IDX_W'(1));

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .i_req   (w_eligible),
    .i_start (w_start),
    .o_gnt   (w_pick_gnt),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_grant_start = 1'b0;
    case (r_state)
      ST_HOLD: begin
        if (!(|(w_eligible & r_gnt))) begin
          w_state_nxt = ST_GAP;
          w_gnt_nxt   = '0;
        end
      end
      default: begin
        if (w_pick_valid) begin
          w_state_nxt   = ST_HOLD;
          w_gnt_nxt     = w_pick_gnt;
          w_grant_start = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_last  <= LAST_IDX;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      if (w_grant_start) r_last <= w_pick_idx;
    end
  end

  // A GCNT write wins over a coincident increment.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_ctrl <= '0;
      r_mask <= '1;
      r_gcnt <= '0;
    end else begin
      if (w_wr_fire && w_wr_mapped && w_wr_sel == REG_CTRL)
        r_ctrl <= w_ctrl_wr[1:0];
      if (w_wr_fire && w_wr_mapped && w_wr_sel == REG_MASK)
        r_mask <= w_mask_wr[NUM_REQ-1:0];
      if (w_wr_fire && w_wr_mapped && w_wr_sel == REG_GCNT)
        r_gcnt <= '0;
      else if (w_grant_start && r_gcnt != '1)
        r_gcnt <= r_gcnt + CNT_W'(1);
    end
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_awready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_RDATA   = r_rdata;
  assign gnt           = r_gnt;

endmodule

// File: tb/tb_axil_rr_arbiter.sv
// Self-checking bench: directed register/arbitration steps plus random
// request traffic compared against a behavioural arbiter model.
module tb_axil_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 5;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] S_AXI_AWADDR = '0;
  logic          S_AXI_AWVALID = 1'b0, S_AXI_AWREADY;
  logic [31:0]   S_AXI_WDATA = '0;
  logic [3:0]    S_AXI_WSTRB = '0;
  logic          S_AXI_WVALID = 1'b0, S_AXI_WREADY;
  logic [1:0]    S_AXI_BRESP;
  logic          S_AXI_BVALID, S_AXI_BREADY = 1'b0;
  logic [AW-1:0] S_AXI_ARADDR = '0;
  logic          S_AXI_ARVALID = 1'b0, S_AXI_ARREADY;
  logic [31:0]   S_AXI_RDATA;
  logic [1:0]    S_AXI_RRESP;
  logic          S_AXI_RVALID, S_AXI_RREADY = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  gnt;

  always #5 clk = ~clk;

  axil_rr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .CNT_W(CW)) dut (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY), .req(req), .gnt(gnt)
  );

  int total = 0;
  int bad   = 0;
  bit rnd_req = 1'b0;

  // Behavioural model: owner index (-1 = none), last owner, shadow registers.
  int          m_owner = -1;
  int          m_last  = N - 1;
  int          m_ctrl  = 0;
  int          m_mask  = (1 << N) - 1;
  int          m_gcnt  = 0;
  logic [31:0] m_rdata = '0;

  function automatic int pick(input int elig, input bit fixed, input int last);
    int start;
    start = fixed ? 0 : (last + 1) % N;
    for (int k = 0; k < N; k++) begin
      if (((elig >> ((start + k) % N)) & 1) == 1) return (start + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [31:0] model_read(input logic [AW-1:0] addr);
    if (addr >= 16) return 32'd0;
    case (addr[3:2])
      2'd0:    return 32'(m_ctrl);
      2'd1:    return 32'(m_mask);
      2'd2:    return (m_owner < 0) ? 32'd0 : ((32'd1 << m_owner) | 32'h8000_0000);
      default: return 32'(m_gcnt);
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1; m_last = N - 1; m_ctrl = 0; m_mask = (1 << N) - 1;
      m_gcnt = 0; m_rdata = '0;
    end else begin
      int elig;
      if (S_AXI_ARREADY && S_AXI_ARVALID) m_rdata = model_read(S_AXI_ARADDR);
      elig = m_ctrl[0] ? (int'(req) & m_mask) : 0;
      if (m_owner >= 0) begin
        if (((elig >> m_owner) & 1) == 0) m_owner = -1;
      end else if (elig != 0) begin
        m_owner = pick(elig, m_ctrl[1], m_last);
        m_last  = m_owner;
        if (m_gcnt < (1 << CW) - 1) m_gcnt++;
      end
      if (S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID && S_AXI_AWADDR < 16) begin
        case (S_AXI_AWADDR[3:2])
          2'd0:    if (S_AXI_WSTRB[0]) m_ctrl = int'(S_AXI_WDATA) & 3;
          2'd1:    if (S_AXI_WSTRB[0]) m_mask = int'(S_AXI_WDATA) & ((1 << N) - 1);
          2'd3:    m_gcnt = 0;
          default: ;
        endcase
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check("gnt_model", 32'(gnt), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
    if (rnd_req) req = N'($urandom | $urandom);
  endtask

  task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input string tag);
    int n = 0;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    tick();
    while (!S_AXI_AWREADY && n < 20) begin tick(); n++; end
    check({tag, "_awready"}, 32'(S_AXI_AWREADY), 32'd1);
    check({tag, "_wready"}, 32'(S_AXI_WREADY), 32'd1);
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    check({tag, "_bvalid"}, 32'(S_AXI_BVALID), 32'd1);
    check({tag, "_bresp"}, 32'(S_AXI_BRESP), (addr >= 16) ? 32'd2 : 32'd0);
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    check({tag, "_bvalid_clr"}, 32'(S_AXI_BVALID), 32'd0);
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input string tag, output logic [31:0] data);
    int n = 0;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    tick();
    while (!S_AXI_ARREADY && n < 20) begin tick(); n++; end
    check({tag, "_arready"}, 32'(S_AXI_ARREADY), 32'd1);
    tick();
    S_AXI_ARVALID = 1'b0;
    check({tag, "_rvalid"}, 32'(S_AXI_RVALID), 32'd1);
    check({tag, "_rdata"}, S_AXI_RDATA, m_rdata);
    check({tag, "_rresp"}, 32'(S_AXI_RRESP), (addr >= 16) ? 32'd2 : 32'd0);
    data = S_AXI_RDATA;
    tick();
    check({tag, "_rhold"}, {31'd0, S_AXI_RVALID} | ((S_AXI_RDATA === m_rdata) ? 32'd0 : 32'd2), 32'd1);
    S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_RREADY = 1'b0;
    check({tag, "_rvalid_clr"}, 32'(S_AXI_RVALID), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=no finish required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] cv;
    logic [3:0]  rr_seq [5];
    int n;
    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
    check("rst_wready", 32'(S_AXI_WREADY), 32'd0);
    check("rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
    check("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
    check("rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
    check("rst_resps", {28'd0, S_AXI_BRESP, S_AXI_RRESP}, 32'd0);
    check("rst_rdata", S_AXI_RDATA, 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    axi_read(5'h00, "rst_ctrl", rd);   check("rst_ctrl_val", rd, 32'd0);
    axi_read(5'h04, "rst_mask", rd);   check("rst_mask_val", rd, 32'hF);
    axi_read(5'h0C, "rst_gcnt", rd);   check("rst_gcnt_val", rd, 32'd0);
    axi_read(5'h08, "rst_status", rd); check("rst_status_val", rd, 32'd0);

    // Round-robin rotation with one idle cycle between owners.
    req = 4'b1111;
    axi_write(5'h04, 32'hF, 4'hF, "rr_mask");
    axi_write(5'h00, 32'h1, 4'hF, "rr_ctrl");
    n = 0;
    while (gnt == '0 && n < 10) begin tick(); n++; end
    check("rr_seq0", 32'(gnt), 32'(rr_seq[0]));
    for (int k = 1; k < 5; k++) begin
      req = 4'b1111 & ~gnt;
      tick();
      check("rr_gap", 32'(gnt), 32'd0);
      req = 4'b1111;
      tick();
      check("rr_seq", 32'(gnt), 32'(rr_seq[k]));
    end

    axi_read(5'h0C, "gcnt5", rd);      check("gcnt5_val", rd, 32'd5);
    axi_write(5'h0C, 32'h0, 4'h0, "gcnt_clr");
    axi_read(5'h0C, "gcnt0", rd);      check("gcnt0_val", rd, 32'd0);

    // Zero strobes leave CTRL alone; masking the owner drops the grant.
    axi_write(5'h00, 32'h0, 4'h0, "strb0");
    axi_read(5'h00, "strb0_ctrl", rd); check("strb0_ctrl_val", rd, 32'd1);
    check("pre_mask_gnt", 32'(gnt), 32'd1);
    axi_write(5'h04, 32'h2, 4'hF, "mask2");
    check("mask_drop_gnt", 32'(gnt), 32'd0);

    // Unmapped offset.
    axi_read(5'h14, "unmapped_rd", rd); check("unmapped_rdata", rd, 32'd0);
    axi_write(5'h14, 32'hFFFF_FFFF, 4'hF, "unmapped_wr");
    axi_read(5'h00, "unmapped_ctrl", rd); check("unmapped_ctrl_val", rd, 32'd1);

    // BREADY stall blocks further writes.
    S_AXI_AWADDR = 5'h00; S_AXI_WDATA = 32'h1; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    tick();
    n = 0;
    while (!S_AXI_AWREADY && n < 20) begin tick(); n++; end
    check("stall_awready", 32'(S_AXI_AWREADY), 32'd1);
    tick();
    for (int i = 0; i < 10; i++) begin
      check("stall_bvalid", 32'(S_AXI_BVALID), 32'd1);
      check("stall_awready_low", 32'(S_AXI_AWREADY), 32'd0);
      tick();
    end
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    tick();
    check("stall_second_aw", 32'(S_AXI_AWREADY), 32'd1);
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    check("stall_second_b", 32'(S_AXI_BVALID), 32'd1);
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;

    // Fixed priority: lowest index wins after a release/re-request.
    req = '0;
    repeat (3) tick();
    axi_write(5'h00, 32'h3, 4'hF, "fx_ctrl");
    axi_write(5'h04, 32'hF, 4'hF, "fx_mask");
    req = 4'b1010;
    n = 0;
    while (gnt == '0 && n < 10) begin tick(); n++; end
    check("fx_first", 32'(gnt), 32'h2);
    req = 4'b1000;
    tick();
    check("fx_gap", 32'(gnt), 32'd0);
    req = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("fx_regrant", 32'(gnt), 32'h2);
    end

    // Random traffic with random configuration per segment.
    rnd_req = 1'b1;
    for (int seg = 0; seg < 8; seg++) begin
      cv = 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) cv[0] = 1'b1;
      axi_write(5'h00, cv, 4'hF, "rnd_ctrl");
      axi_write(5'h04, $urandom, 4'($urandom), "rnd_mask");
      repeat (40) tick();
      axi_read(5'h08, "rnd_status", rd);
      axi_read(5'h0C, "rnd_gcnt", rd);
    end
    rnd_req = 1'b0;

    // Reset during a held grant aborts a pending response.
    req = 4'b0001;
    axi_write(5'h00, 32'h1, 4'hF, "ar_ctrl");
    n = 0;
    while (gnt == '0 && n < 10) begin tick(); n++; end
    check("ar_held", 32'(gnt), 32'h1);
    S_AXI_AWADDR = 5'h04; S_AXI_WDATA = 32'h1; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    tick();
    n = 0;
    while (!S_AXI_AWREADY && n < 20) begin tick(); n++; end
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    check("ar_bpending", 32'(S_AXI_BVALID), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_gnt_async", 32'(gnt), 32'd0);
    check("ar_bvalid_abort", 32'(S_AXI_BVALID), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    axi_read(5'h00, "ar_ctrl_rd", rd); check("ar_ctrl_val", rd, 32'd0);
    axi_read(5'h04, "ar_mask_rd", rd); check("ar_mask_val", rd, 32'hF);
    check("ar_gnt_idle", 32'(gnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
